pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
Pipelined successor to the team's single-cycle control decoder for the 5-stage MIPS core with forwarding. It decodes the ID-stage instruction fields and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards, squashes on taken branch/jump, flags illegal opcodes and counts inserted bubbles. Upstream PC/IF/ID logic consumes stall_out and flush_out.

Parameters:
ALUOP_W, 4, ALU operation code width
REG_ADDR_W, 5, register-specifier width
CNT_W, 16, width of saturating bubble counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
opcode  in  6  instr[31:26]
funct  in  6  instr[5:0]
rs  in  REG_ADDR_W  instr[25:21]
rt  in  REG_ADDR_W  instr[20:16]
rd  in  REG_ADDR_W  instr[15:11]
ex_branch_taken  in  1  BEQ in EX resolved taken
stall_out  out  1  hold PC and IF/ID this cycle
flush_out  out  1  clear IF/ID this cycle
illegal_op  out  1  one-cycle pulse: unsupported opcode entered ID/EX
ex_alu_op  out  ALUOP_W  ALU code (FUNC=4'b1111 for R-type)
ex_alu_src, ex_use_shamt, ex_sign_ext, ex_branch, ex_jump  out  1 each  EX controls
ex_dest  out  REG_ADDR_W  destination register in EX
mem_read, mem_write  out  1 each  MEM controls
mem_dest  out  REG_ADDR_W  destination register in MEM
wb_reg_write, wb_mem_to_reg  out  1 each  WB controls
wb_dest  out  REG_ADDR_W  destination register in WB
bubble_count  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset: all pipeline control registers, all outputs and bubble_count clear to 0 asynchronously. Every register is a bubble after reset.
- Decode is combinational. No X is ever driven; don't-cares decode to 0.
- ALU codes: AND 0, OR 1, ADD 2, SUB 6, SLT 7, XOR 10, SLTU 11, LUI 14, FUNC 15.
- R-type (000000): ALU=FUNC, dest=rd, reg_write=1. use_shamt=1 iff funct is 000000, 000010 or 000011. Reads rs and rt.
- LW (100011): ADD, alu_src, sign_ext, mem_read, mem_to_reg, reg_write, dest=rt. Reads rs.
- SW (101011): ADD, alu_src, sign_ext, mem_write, dest=0. Reads rs and rt.
- BEQ (000100): SUB, branch, sign_ext, dest=0. Reads rs and rt.
- J (000010): jump, dest=0.
- ADDI (001000) and ADDIU (001001): ADD, sign_ext.
- SLTI (001010): SLT, sign_ext. SLTIU (001011): SLTU, sign_ext.
- ANDI (001100): AND, zero-ext. ORI (001101): OR, zero-ext. XORI (001110): XOR, zero-ext. LUI (001111): LUI, zero-ext.
- All I-type ALU ops: alu_src=1, reg_write=1, dest=rt, read rs only.
- A decoded dest of 0 forces reg_write=0.
- Pipeline: ID/EX -> EX/MEM -> MEM/WB advance every clock and never stall internally. Latency from ID decode to ex_* is 1 cycle, to mem_* 2 cycles, to wb_* 3 cycles.
- Load-use hazard: asserted when id_valid, mem_read is set in ID/EX, ex_dest!=0, and ex_dest equals rs, or equals rt for an instruction that reads rt.
  - Response: stall_out=1 and a bubble is loaded into ID/EX.
  - Exactly one stall cycle per hazard, because the load moves to MEM on the next cycle.
- Flush condition: ex_branch_taken, or ex_jump set in ID/EX.
  - Response: flush_out=1, bubble loaded into ID/EX, stall_out forced to 0.
  - Flush has priority over stall when both occur together.
- Illegal opcode with id_valid and no flush/stall: bubble loaded, illegal_op pulses 1 the next cycle.
- id_valid=0: bubble loaded, not counted.
- bubble_count increments by 1 per cycle in which a stall, flush or illegal bubble is inserted. It saturates at all-ones.
- Reset asserted mid-operation discards all in-flight controls immediately.

Test Plan:
- Reset asserted with arbitrary inputs: every output reads 0 during reset and on the first edge after release.
- Single ADDI r3 with id_valid=1: next cycle ex_alu_op=2, ex_alu_src=1, ex_sign_ext=1, ex_dest=3. Two cycles later wb_reg_write=1, wb_dest=3.
- LW r5 followed by ADD r6,r5,r1: stall_out=1 for exactly one cycle, one bubble in EX, bubble_count=1. The ADD reaches EX one cycle late with ex_alu_op=15.
- Drive ex_branch_taken=1 in the same cycle a load-use hazard is present: flush_out=1, stall_out=0, ID/EX holds a bubble.
- Opcode 111111 with id_valid=1: illegal_op pulses for 1 cycle, ex/mem/wb controls stay 0, bubble_count increments.
- ADDI with destination r0: wb_reg_write=0. Issue an SLL (funct 000000): ex_use_shamt=1. Force bubble_count to all-ones, then insert one more bubble: bubble_count holds at all-ones.

Source files
------------

// File: rtl/pipelined_control_unit_if.sv
// ID-stage decode inputs and the staged control bundle of the pipelined control unit.
// The bench or ID stage drives the master side. The control unit is the slave.
interface pipelined_control_unit_if #(
  parameter int ALUOP_W    = 4,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic                  ex_branch_taken;

  logic                  stall_out;
  logic                  flush_out;
  logic                  illegal_op;
  logic [ALUOP_W-1:0]    ex_alu_op;
  logic                  ex_alu_src;
  logic                  ex_use_shamt;
  logic                  ex_sign_ext;
  logic                  ex_branch;
  logic                  ex_jump;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  mem_read;
  logic                  mem_write;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  wb_reg_write;
  logic                  wb_mem_to_reg;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic [CNT_W-1:0]      bubble_count;

  modport master (
    output id_valid, opcode, funct, rs, rt, rd, ex_branch_taken,
    input  stall_out, flush_out, illegal_op,
    input  ex_alu_op, ex_alu_src, ex_use_shamt, ex_sign_ext, ex_branch, ex_jump, ex_dest,
    input  mem_read, mem_write, mem_dest,
    input  wb_reg_write, wb_mem_to_reg, wb_dest, bubble_count
  );

  modport slave (
    input  id_valid, opcode, funct, rs, rt, rd, ex_branch_taken,
    output stall_out, flush_out, illegal_op,
    output ex_alu_op, ex_alu_src, ex_use_shamt, ex_sign_ext, ex_branch, ex_jump, ex_dest,
    output mem_read, mem_write, mem_dest,
    output wb_reg_write, wb_mem_to_reg, wb_dest, bubble_count
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Control decoder for the 5-stage MIPS core: decodes in ID and carries controls through ID/EX, EX/MEM and MEM/WB.
// It also detects load-use stalls, squashes on a taken branch or jump, flags illegal opcodes and counts bubbles.
module pipelined_control_unit #(
  parameter int ALUOP_W    = 4,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic reset,
  pipelined_control_unit_if.slave bus
);

  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(14);
  localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(15);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic [ALUOP_W-1:0]    alu_op;
    logic                  alu_src;
    logic                  use_shamt;
    logic                  sign_ext;
    logic                  branch;
    logic                  jump;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] dest;
  } ex_ctl_t;

  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] dest;
  } mem_ctl_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] dest;
  } wb_ctl_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  ex_ctl_t          ctl_p0;
  logic             legal_p0;
  logic             reads_rt_p0;
  logic             itype_p0;
  logic             flush_p0;
  logic             hazard_p0;
  logic             stall_p0;

  ex_ctl_t          ctl_p1_d, ctl_p1_q;
  mem_ctl_t         ctl_p2_d, ctl_p2_q;
  wb_ctl_t          ctl_p3_d, ctl_p3_q;
  logic             illegal_d, illegal_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

  // ---- p0: combinational decode of the instruction held in ID ----
  always_comb begin
    ctl_p0      = '0;
    legal_p0    = 1'b1;
    reads_rt_p0 = 1'b0;
    itype_p0    = 1'b0;
    unique case (bus.opcode)
      OP_RTYPE: begin
        ctl_p0.alu_op    = ALU_FUNC;
        ctl_p0.reg_write = 1'b1;
        ctl_p0.dest      = bus.rd;
        ctl_p0.use_shamt = (bus.funct == 6'b000000) || (bus.funct == 6'b000010) ||
                           (bus.funct == 6'b000011);
        reads_rt_p0      = 1'b1;
      end
      OP_LW: begin
        ctl_p0.alu_op     = ALU_ADD;
        ctl_p0.alu_src    = 1'b1;
        ctl_p0.sign_ext   = 1'b1;
        ctl_p0.mem_read   = 1'b1;
        ctl_p0.mem_to_reg = 1'b1;
        ctl_p0.reg_write  = 1'b1;
        ctl_p0.dest       = bus.rt;
      end
      OP_SW: begin
        ctl_p0.alu_op    = ALU_ADD;
        ctl_p0.alu_src   = 1'b1;
        ctl_p0.sign_ext  = 1'b1;
        ctl_p0.mem_write = 1'b1;
        reads_rt_p0      = 1'b1;
      end
      OP_BEQ: begin
        ctl_p0.alu_op   = ALU_SUB;
        ctl_p0.branch   = 1'b1;
        ctl_p0.sign_ext = 1'b1;
        reads_rt_p0     = 1'b1;
      end
      OP_J: ctl_p0.jump = 1'b1;
      OP_ADDI, OP_ADDIU: begin
        ctl_p0.alu_op   = ALU_ADD;
        ctl_p0.sign_ext = 1'b1;
        itype_p0        = 1'b1;
      end
      OP_SLTI: begin
        ctl_p0.alu_op   = ALU_SLT;
        ctl_p0.sign_ext = 1'b1;
        itype_p0        = 1'b1;
      end
      OP_SLTIU: begin
        ctl_p0.alu_op   = ALU_SLTU;
        ctl_p0.sign_ext = 1'b1;
        itype_p0        = 1'b1;
      end
      OP_ANDI: begin
        ctl_p0.alu_op = ALU_AND;
        itype_p0      = 1'b1;
      end
      OP_ORI: begin
        ctl_p0.alu_op = ALU_OR;
        itype_p0      = 1'b1;
      end
      OP_XORI: begin
        ctl_p0.alu_op = ALU_XOR;
        itype_p0      = 1'b1;
      end
      OP_LUI: begin
        ctl_p0.alu_op = ALU_LUI;
        itype_p0      = 1'b1;
      end
      default: legal_p0 = 1'b0;
    endcase
    if (itype_p0) begin
      ctl_p0.alu_src   = 1'b1;
      ctl_p0.reg_write = 1'b1;
      ctl_p0.dest      = bus.rt;
    end
    // r0 is hardwired, so writing it must never look like a real producer.
    if (ctl_p0.dest == '0) ctl_p0.reg_write = 1'b0;
  end

  // ---- p0 -> p1: hazard/flush resolution and next-state for every stage ----
  always_comb begin
    flush_p0  = bus.ex_branch_taken | ctl_p1_q.jump;
    hazard_p0 = bus.id_valid && ctl_p1_q.mem_read && (ctl_p1_q.dest != '0) &&
                ((ctl_p1_q.dest == bus.rs) || (reads_rt_p0 && (ctl_p1_q.dest == bus.rt)));
    stall_p0  = hazard_p0 & ~flush_p0;

    ctl_p1_d = '0;
    if (!(flush_p0 || hazard_p0 || !bus.id_valid || !legal_p0)) ctl_p1_d = ctl_p0;

    ctl_p2_d = '{mem_read:   ctl_p1_q.mem_read,
                 mem_write:  ctl_p1_q.mem_write,
                 reg_write:  ctl_p1_q.reg_write,
                 mem_to_reg: ctl_p1_q.mem_to_reg,
                 dest:       ctl_p1_q.dest};
    ctl_p3_d = '{reg_write:  ctl_p2_q.reg_write,
                 mem_to_reg: ctl_p2_q.mem_to_reg,
                 dest:       ctl_p2_q.dest};

    illegal_d    = bus.id_valid & ~legal_p0 & ~flush_p0 & ~hazard_p0;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_p0 || hazard_p0 || illegal_d) bubble_cnt_d = sat_inc(bubble_cnt_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_p1_q     <= '0;
      ctl_p2_q     <= '0;
      ctl_p3_q     <= '0;
      illegal_q    <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      ctl_p1_q     <= ctl_p1_d;
      ctl_p2_q     <= ctl_p2_d;
      ctl_p3_q     <= ctl_p3_d;
      illegal_q    <= illegal_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // ---- outputs: EX from p1, MEM from p2, WB from p3 ----
  // Flush follows a raw input, so it is gated to keep every output at 0 while reset is held.
  assign bus.stall_out     = stall_p0 & ~reset;
  assign bus.flush_out     = flush_p0 & ~reset;
  assign bus.illegal_op    = illegal_q;
  assign bus.ex_alu_op     = ctl_p1_q.alu_op;
  assign bus.ex_alu_src    = ctl_p1_q.alu_src;
  assign bus.ex_use_shamt  = ctl_p1_q.use_shamt;
  assign bus.ex_sign_ext   = ctl_p1_q.sign_ext;
  assign bus.ex_branch     = ctl_p1_q.branch;
  assign bus.ex_jump       = ctl_p1_q.jump;
  assign bus.ex_dest       = ctl_p1_q.dest;
  assign bus.mem_read      = ctl_p2_q.mem_read;
  assign bus.mem_write     = ctl_p2_q.mem_write;
  assign bus.mem_dest      = ctl_p2_q.dest;
  assign bus.wb_reg_write  = ctl_p3_q.reg_write;
  assign bus.wb_mem_to_reg = ctl_p3_q.mem_to_reg;
  assign bus.wb_dest       = ctl_p3_q.dest;
  assign bus.bubble_count  = bubble_cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed and randomized bench for pipelined_control_unit against a cycle-level instruction model.
// A small bubble counter width keeps saturation reachable in a short run.
module tb_pipelined_control_unit;
  localparam int ALUOP_W    = 4;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 5;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipelined_control_unit_if #(.ALUOP_W(ALUOP_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();

  pipelined_control_unit #(.ALUOP_W(ALUOP_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] alu;
    logic       src, shamt, sext, br, jmp, mr, mw, rw, m2r;
    logic [4:0] dest;
    logic       legal, rrt;
  } mctl_t;

  mctl_t ex_m, mem_m, wb_m;
  logic  ill_m;
  int    bub_m;

  function automatic mctl_t empty_ctl();
    mctl_t c;
    c = '{default: '0};
    return c;
  endfunction

  // Instruction semantics written from the ISA table, one opcode at a time.
  function automatic mctl_t model_dec(logic [5:0] op, logic [5:0] fn, logic [4:0] rt, logic [4:0] rd);
    mctl_t c;
    c = empty_ctl();
    c.legal = 1'b1;
    case (op)
      6'h00: begin c.alu = 4'd15; c.rw = 1; c.dest = rd; c.rrt = 1;
                   c.shamt = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03); end
      6'h23: begin c.alu = 4'd2; c.src = 1; c.sext = 1; c.mr = 1; c.m2r = 1; c.rw = 1; c.dest = rt; end
      6'h2b: begin c.alu = 4'd2; c.src = 1; c.sext = 1; c.mw = 1; c.rrt = 1; end
      6'h04: begin c.alu = 4'd6; c.br = 1; c.sext = 1; c.rrt = 1; end
      6'h02: c.jmp = 1;
      6'h08, 6'h09: begin c.alu = 4'd2;  c.sext = 1; end
      6'h0a:        begin c.alu = 4'd7;  c.sext = 1; end
      6'h0b:        begin c.alu = 4'd11; c.sext = 1; end
      6'h0c:        c.alu = 4'd0;
      6'h0d:        c.alu = 4'd1;
      6'h0e:        c.alu = 4'd10;
      6'h0f:        c.alu = 4'd14;
      default:      c.legal = 1'b0;
    endcase
    if (op >= 6'h08 && op <= 6'h0f) begin c.src = 1; c.rw = 1; c.dest = rt; end
    if (c.dest == 5'd0) c.rw = 1'b0;
    return c;
  endfunction

  function automatic logic model_hz();
    mctl_t d;
    d = model_dec(bus.opcode, bus.funct, bus.rt, bus.rd);
    return bus.id_valid && ex_m.mr && (ex_m.dest != 5'd0) &&
           ((ex_m.dest == bus.rs) || (d.rrt && (ex_m.dest == bus.rt)));
  endfunction

  function automatic logic model_fl();
    return bus.ex_branch_taken || ex_m.jmp;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic hz, fl;
    hz = model_hz();
    fl = model_fl();
    chk("stall_out",     32'(bus.stall_out),     32'(hz && !fl));
    chk("flush_out",     32'(bus.flush_out),     32'(fl));
    chk("illegal_op",    32'(bus.illegal_op),    32'(ill_m));
    chk("ex_alu_op",     32'(bus.ex_alu_op),     32'(ex_m.alu));
    chk("ex_alu_src",    32'(bus.ex_alu_src),    32'(ex_m.src));
    chk("ex_use_shamt",  32'(bus.ex_use_shamt),  32'(ex_m.shamt));
    chk("ex_sign_ext",   32'(bus.ex_sign_ext),   32'(ex_m.sext));
    chk("ex_branch",     32'(bus.ex_branch),     32'(ex_m.br));
    chk("ex_jump",       32'(bus.ex_jump),       32'(ex_m.jmp));
    chk("ex_dest",       32'(bus.ex_dest),       32'(ex_m.dest));
    chk("mem_read",      32'(bus.mem_read),      32'(mem_m.mr));
    chk("mem_write",     32'(bus.mem_write),     32'(mem_m.mw));
    chk("mem_dest",      32'(bus.mem_dest),      32'(mem_m.dest));
    chk("wb_reg_write",  32'(bus.wb_reg_write),  32'(wb_m.rw));
    chk("wb_mem_to_reg", 32'(bus.wb_mem_to_reg), 32'(wb_m.m2r));
    chk("wb_dest",       32'(bus.wb_dest),       32'(wb_m.dest));
    chk("bubble_count",  32'(bus.bubble_count),  32'(bub_m));
  endtask

  task automatic check_zero(input string phase);
    logic [31:0] all_or;
    all_or = 32'(bus.stall_out) | 32'(bus.flush_out) | 32'(bus.illegal_op) | 32'(bus.ex_alu_op) |
             32'(bus.ex_alu_src) | 32'(bus.ex_use_shamt) | 32'(bus.ex_sign_ext) | 32'(bus.ex_branch) |
             32'(bus.ex_jump) | 32'(bus.ex_dest) | 32'(bus.mem_read) | 32'(bus.mem_write) |
             32'(bus.mem_dest) | 32'(bus.wb_reg_write) | 32'(bus.wb_mem_to_reg) | 32'(bus.wb_dest);
    chk({phase, "_ctl_or"}, all_or, 32'd0);
    chk({phase, "_flush"}, 32'(bus.flush_out), 32'd0);
    chk({phase, "_bubble_count"}, 32'(bus.bubble_count), 32'd0);
  endtask

  task automatic model_step();
    mctl_t d;
    logic  hz, fl;
    d  = model_dec(bus.opcode, bus.funct, bus.rt, bus.rd);
    hz = model_hz();
    fl = model_fl();
    wb_m  = mem_m;
    mem_m = ex_m;
    ex_m  = (fl || hz || !bus.id_valid || !d.legal) ? empty_ctl() : d;
    if ((fl || hz || (bus.id_valid && !d.legal)) && bub_m < CNT_MAX) bub_m++;
    ill_m = bus.id_valid && !d.legal && !fl && !hz;
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_i(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs_i, input logic [4:0] rt_i, input logic [4:0] rd_i,
                       input logic bt);
    bus.id_valid = v; bus.opcode = op; bus.funct = fn;
    bus.rs = rs_i; bus.rt = rt_i; bus.rd = rd_i; bus.ex_branch_taken = bt;
  endtask

  task automatic idle();
    set_i(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_i(1'b1, 6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'b1);
    #2;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_held");
    @(negedge clk);
    idle();
    reset = 1'b0;
    ex_m = empty_ctl(); mem_m = empty_ctl(); wb_m = empty_ctl(); ill_m = 1'b0; bub_m = 0;
    @(posedge clk);
    #1;
    check_zero("rst_release");
    model_step();
  endtask

  logic [5:0] legal_ops [13] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h09,
                                 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
  logic [5:0] r_functs [6]   = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h22, 6'h2a};

  initial begin
    ex_m = empty_ctl(); mem_m = empty_ctl(); wb_m = empty_ctl(); ill_m = 1'b0; bub_m = 0;
    do_reset();

    // ADDI r3, r1: EX one cycle later, WB three cycles later
    set_i(1'b1, 6'h08, 6'h00, 5'd1, 5'd3, 5'd0, 1'b0);
    tick();
    idle();
    #1;
    chk("addi_ex_alu_op",  32'(bus.ex_alu_op),   32'd2);
    chk("addi_ex_alu_src", 32'(bus.ex_alu_src),  32'd1);
    chk("addi_ex_sext",    32'(bus.ex_sign_ext), 32'd1);
    chk("addi_ex_dest",    32'(bus.ex_dest),     32'd3);
    tick();
    tick();
    chk("addi_wb_rw",   32'(bus.wb_reg_write), 32'd1);
    chk("addi_wb_dest", 32'(bus.wb_dest),      32'd3);
    tick();

    // LW r5 then ADD r6,r5,r1: exactly one stall cycle
    set_i(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
    tick();
    set_i(1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd6, 1'b0);
    #1;
    chk("lu_stall_first", 32'(bus.stall_out), 32'd1);
    tick();
    chk("lu_stall_second", 32'(bus.stall_out),    32'd0);
    chk("lu_ex_bubble",    32'(bus.ex_alu_op),    32'd0);
    chk("lu_bubble_count", 32'(bus.bubble_count), 32'd1);
    tick();
    idle();
    #1;
    chk("lu_add_alu_op", 32'(bus.ex_alu_op), 32'd15);
    chk("lu_add_dest",   32'(bus.ex_dest),   32'd6);
    tick();
    tick();

    // Load-use hazard coinciding with a taken branch: flush wins
    set_i(1'b1, 6'h23, 6'h00, 5'd2, 5'd7, 5'd0, 1'b0);
    tick();
    set_i(1'b1, 6'h00, 6'h20, 5'd7, 5'd7, 5'd9, 1'b1);
    #1;
    chk("fl_flush", 32'(bus.flush_out), 32'd1);
    chk("fl_stall", 32'(bus.stall_out), 32'd0);
    tick();
    idle();
    #1;
    chk("fl_ex_alu_op", 32'(bus.ex_alu_op),  32'd0);
    chk("fl_ex_dest",   32'(bus.ex_dest),    32'd0);
    chk("fl_ex_src",    32'(bus.ex_alu_src), 32'd0);
    tick();
    tick();

    // Illegal opcode 111111
    set_i(1'b1, 6'h3f, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    idle();
    #1;
    chk("ill_pulse",   32'(bus.illegal_op),   32'd1);
    chk("ill_ex_op",   32'(bus.ex_alu_op),    32'd0);
    chk("ill_ex_dest", 32'(bus.ex_dest),      32'd0);
    chk("ill_count",   32'(bus.bubble_count), 32'(bub_m));
    tick();
    chk("ill_pulse_end", 32'(bus.illegal_op), 32'd0);
    tick();

    // ADDI to r0 never writes; SLL decodes use_shamt
    set_i(1'b1, 6'h08, 6'h00, 5'd4, 5'd0, 5'd0, 1'b0);
    tick();
    set_i(1'b1, 6'h00, 6'h00, 5'd0, 5'd3, 5'd8, 1'b0);
    tick();
    idle();
    #1;
    chk("sll_shamt", 32'(bus.ex_use_shamt), 32'd1);
    tick();
    chk("addi_r0_wb_rw", 32'(bus.wb_reg_write), 32'd0);
    tick();
    tick();

    // Saturate the bubble counter, then one more bubble
    do_reset();
    set_i(1'b1, 6'h3f, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < CNT_MAX; i++) tick();
    chk("sat_full", 32'(bus.bubble_count), 32'(CNT_MAX));
    tick();
    chk("sat_hold", 32'(bus.bubble_count), 32'(CNT_MAX));
    idle();
    tick();

    // Randomized traffic with upstream hold on stall and a mid-run reset
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic held;
      held = model_hz() && !model_fl();
      if (n == 300) begin
        do_reset();
        held = 1'b0;
      end
      if (!held) begin
        bus.id_valid = ($urandom_range(0, 9) < 8);
        bus.opcode   = ($urandom_range(0, 15) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 12)];
        bus.funct    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : r_functs[$urandom_range(0, 5)];
        bus.rs       = 5'($urandom_range(0, 3));
        bus.rt       = 5'($urandom_range(0, 3));
        bus.rd       = 5'($urandom_range(0, 3));
      end
      bus.ex_branch_taken = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
